// File: rtl/banco_registradores_pkg.sv
// Definitions shared by the register file, the ULA and the control path.
package banco_registradores_pkg;

   localparam int LARGURA  = 32;
   localparam int END_BITS = 5;

   localparam logic [END_BITS-1:0] REG_ZERO = '0;

   // ALUControl encodings used by the ULA that consumes the read ports
   localparam logic [2:0] SOMA = 3'b010;
   localparam logic [2:0] SUB  = 3'b110;
   localparam logic [2:0] AND  = 3'b000;
   localparam logic [2:0] OR   = 3'b001;
   localparam logic [2:0] SLT  = 3'b111;

endpackage

// File: rtl/banco_registradores.sv
// Register file feeding the ULA: two registered read ports with write bypass,
// one synchronous write port, register 0 hardwired to zero.
module banco_registradores #(
   parameter int LARGURA  = banco_registradores_pkg::LARGURA,
   parameter int NUM_REGS = 32,
   parameter int END_BITS = banco_registradores_pkg::END_BITS
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [END_BITS-1:0] reg_leitura1,
   input  logic [END_BITS-1:0] reg_leitura2,
   input  logic [END_BITS-1:0] reg_escrita,
   input  logic [LARGURA-1:0]  dado_escrita,
   input  logic                RegWrite,
   output logic [LARGURA-1:0]  dado_leitura1,
   output logic [LARGURA-1:0]  dado_leitura2
);
   import banco_registradores_pkg::*;

   localparam logic [END_BITS-1:0] END_ZERO = END_BITS'(REG_ZERO);

   logic [LARGURA-1:0] mem_q [NUM_REGS];
   logic [LARGURA-1:0] dado1_q, dado1_d;
   logic [LARGURA-1:0] dado2_q, dado2_d;
   logic               escreve;

   assign escreve = RegWrite && (reg_escrita != END_ZERO);

   // Address 0 wins over the bypass, so a dropped write to r0 never leaks out
   function automatic logic [LARGURA-1:0] le_porta(
      input logic [END_BITS-1:0] endereco,
      input logic                we,
      input logic [END_BITS-1:0] end_escrita,
      input logic [LARGURA-1:0]  dado_novo,
      input logic [LARGURA-1:0]  dado_mem
   );
      if (endereco == END_ZERO)
         return '0;
      else if (we && (end_escrita == endereco))
         return dado_novo;
      else
         return dado_mem;
   endfunction

   always_comb begin
      dado1_d = le_porta(reg_leitura1, RegWrite, reg_escrita, dado_escrita, mem_q[reg_leitura1]);
      dado2_d = le_porta(reg_leitura2, RegWrite, reg_escrita, dado_escrita, mem_q[reg_leitura2]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            mem_q[i] <= '0;
         dado1_q <= '0;
         dado2_q <= '0;
      end else begin
         if (escreve)
            mem_q[reg_escrita] <= dado_escrita;
         dado1_q <= dado1_d;
         dado2_q <= dado2_d;
      end
   end

   assign dado_leitura1 = dado1_q;
   assign dado_leitura2 = dado2_q;

endmodule
